// File: rtl/l1_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped L1 data cache.
package l1_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_FILL = 2'd2,
        ST_WR_THRU = 2'd3
    } cache_state_e;

    // Byte-offset bits inside one word.
    function automatic int unsigned off_width(input int unsigned data_width);
        return $clog2(data_width / 32'd8);
    endfunction

    // Word-offset bits inside one line.
    function automatic int unsigned woff_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Set-index bits.
    function automatic int unsigned idx_width(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag bits: whatever remains above index, word offset and byte offset.
    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned data_width,
                                              input int unsigned num_sets,
                                              input int unsigned words_per_line);
        return addr_width - off_width(data_width) - woff_width(words_per_line)
               - idx_width(num_sets);
    endfunction

    // Extracts addr[lsb +: width], zero-extended to 64 bits.
    function automatic logic [63:0] addr_field(input logic [63:0]  addr,
                                               input int unsigned  lsb,
                                               input int unsigned  width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/l1_tag_array.sv
// Valid/tag storage with two combinational lookup ports (CPU read and CPU
// write addresses) and one install port used when a refill completes.
module l1_tag_array
    import l1_cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned TAG_W    = 23
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    output logic             wr_hit,
    input  logic             set_valid,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [TAG_W-1:0] set_tag
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] valid_d;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];

    // Next valid vector: a completed refill marks its set valid.
    always_comb begin
        valid_d = valid_q;
        if (set_valid) begin
            valid_d[set_idx] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits clear on reset so partially filled lines never hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {NUM_SETS{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag storage is not reset; it is only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_q[set_idx] <= set_tag;
        end
    end

    // Combinational hit compare for both CPU ports.
    always_comb begin
        rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    end

endmodule

// File: rtl/l1_dcache_dm.sv
// Direct-mapped write-through L1 data cache with read-allocate burst refill.
module l1_dcache_dm
    import l1_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DATA_ADDR_WIDTH = 32,
    parameter int unsigned NUM_SETS        = 16,
    parameter int unsigned WORDS_PER_LINE  = 8
)(
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic                       data_mem_hazard,
    input  logic                       cpu_data_mem_write,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    output logic                       mem_rd_req,
    output logic [DATA_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                       mem_rd_ack,
    input  logic                       mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]      mem_rd_data,
    output logic                       mem_wr_req,
    output logic [DATA_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]      mem_wr_data,
    input  logic                       mem_wr_ack
);

    localparam int unsigned OFF_W   = off_width(DATA_WIDTH);
    localparam int unsigned WOFF_W  = woff_width(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = idx_width(NUM_SETS);
    localparam int unsigned TAG_W   = tag_width(DATA_ADDR_WIDTH, DATA_WIDTH, NUM_SETS, WORDS_PER_LINE);
    localparam int unsigned IDX_LSB = OFF_W + WOFF_W;
    localparam int unsigned TAG_LSB = OFF_W + WOFF_W + IDX_W;
    localparam logic [WOFF_W-1:0] CNT_ONE  = WOFF_W'(32'd1);
    localparam logic [WOFF_W-1:0] CNT_LAST = WOFF_W'(WORDS_PER_LINE - 32'd1);

    cache_state_e               state_q, state_d;
    logic [TAG_W-1:0]           line_tag_q, line_tag_d;
    logic [IDX_W-1:0]           line_idx_q, line_idx_d;
    logic [WOFF_W-1:0]          cnt_q, cnt_d;
    logic [DATA_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]      data_q [NUM_SETS][WORDS_PER_LINE];

    logic [TAG_W-1:0]      rd_tag_s, wr_tag_s;
    logic [IDX_W-1:0]      rd_idx_s, wr_idx_s;
    logic [WOFF_W-1:0]     rd_woff_s, wr_woff_s;
    logic                  rd_hit_s, wr_hit_s, set_valid_s;
    logic                  data_we_s;
    logic [IDX_W-1:0]      data_set_s;
    logic [WOFF_W-1:0]     data_word_s;
    logic [DATA_WIDTH-1:0] data_val_s;

    // Split both CPU addresses into tag / set index / word offset.
    always_comb begin
        rd_woff_s = WOFF_W'(addr_field(64'(cpu_data_mem_raddr), OFF_W, WOFF_W));
        rd_idx_s  = IDX_W'(addr_field(64'(cpu_data_mem_raddr), IDX_LSB, IDX_W));
        rd_tag_s  = TAG_W'(addr_field(64'(cpu_data_mem_raddr), TAG_LSB, TAG_W));
        wr_woff_s = WOFF_W'(addr_field(64'(cpu_data_mem_waddr), OFF_W, WOFF_W));
        wr_idx_s  = IDX_W'(addr_field(64'(cpu_data_mem_waddr), IDX_LSB, IDX_W));
        wr_tag_s  = TAG_W'(addr_field(64'(cpu_data_mem_waddr), TAG_LSB, TAG_W));
    end

    l1_tag_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_tags (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .rd_idx    (rd_idx_s),
        .rd_tag    (rd_tag_s),
        .rd_hit    (rd_hit_s),
        .wr_idx    (wr_idx_s),
        .wr_tag    (wr_tag_s),
        .wr_hit    (wr_hit_s),
        .set_valid (set_valid_s),
        .set_idx   (line_idx_q),
        .set_tag   (line_tag_q)
    );

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q    <= ST_IDLE;
            line_tag_q <= {TAG_W{1'b0}};
            line_idx_q <= {IDX_W{1'b0}};
            cnt_q      <= {WOFF_W{1'b0}};
            wr_addr_q  <= {DATA_ADDR_WIDTH{1'b0}};
            wr_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            line_tag_q <= line_tag_d;
            line_idx_q <= line_idx_d;
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next state, latched request fields and the single data-array write port.
    always_comb begin
        state_d     = state_q;
        line_tag_d  = line_tag_q;
        line_idx_d  = line_idx_q;
        cnt_d       = cnt_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        set_valid_s = 1'b0;
        data_we_s   = 1'b0;
        data_set_s  = line_idx_q;
        data_word_s = cnt_q;
        data_val_s  = mem_rd_data;
        case (state_q)
            ST_IDLE: begin
                // A read miss stalls the CPU, so a simultaneous write waits.
                if (cpu_data_mem_read && !rd_hit_s) begin
                    state_d    = ST_RD_REQ;
                    line_tag_d = rd_tag_s;
                    line_idx_d = rd_idx_s;
                end else if (cpu_data_mem_write) begin
                    state_d   = ST_WR_THRU;
                    wr_addr_d = cpu_data_mem_waddr;
                    wr_data_d = cpu_data_mem_wdata;
                    if (wr_hit_s) begin
                        data_we_s   = 1'b1;
                        data_set_s  = wr_idx_s;
                        data_word_s = wr_woff_s;
                        data_val_s  = cpu_data_mem_wdata;
                    end else begin
                        data_we_s = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (mem_rd_ack) begin
                    state_d = ST_RD_FILL;
                    cnt_d   = {WOFF_W{1'b0}};
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_FILL: begin
                if (mem_rd_valid) begin
                    data_we_s = 1'b1;
                    cnt_d     = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        set_valid_s = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_RD_FILL;
                    end
                end else begin
                    state_d = ST_RD_FILL;
                end
            end
            ST_WR_THRU: begin
                if (mem_wr_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_THRU;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line data storage; refill beats and write hits share one write port.
    always_ff @(posedge cpu_clk) begin
        if (data_we_s) begin
            data_q[data_set_s][data_word_s] <= data_val_s;
        end
    end

    // CPU-facing and memory-facing outputs; hazard and rdata are forced low in reset.
    always_comb begin
        data_mem_hazard = 1'b0;
        data_mem_rdata  = {DATA_WIDTH{1'b0}};
        mem_rd_req      = 1'b0;
        mem_wr_req      = 1'b0;
        if (cpu_rst) begin
            data_mem_hazard = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_data_mem_read && !rd_hit_s) begin
                        data_mem_hazard = 1'b1;
                    end else if (cpu_data_mem_read) begin
                        data_mem_rdata = data_q[rd_idx_s][rd_woff_s];
                    end else begin
                        data_mem_hazard = 1'b0;
                    end
                end
                ST_RD_REQ: begin
                    mem_rd_req      = 1'b1;
                    data_mem_hazard = cpu_data_mem_read | cpu_data_mem_write;
                end
                ST_WR_THRU: begin
                    mem_wr_req      = 1'b1;
                    data_mem_hazard = cpu_data_mem_read | cpu_data_mem_write;
                end
                default: begin
                    data_mem_hazard = cpu_data_mem_read | cpu_data_mem_write;
                end
            endcase
        end
    end

    assign mem_rd_addr = {line_tag_q, line_idx_q, {(WOFF_W + OFF_W){1'b0}}};
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;

endmodule

// File: doc/l1_dcache_dm.md
Name: l1_dcache_dm

Overview:
Parametrised direct-mapped L1 data cache. Sits between the CPU data-memory port and a backing memory/DMA port. Read-allocate with burst line refill; write-through with no write-allocate. Generalises the single-cycle local data memory with configurable sets and line size, hit/miss detection, a refill FSM, and backing-memory handshakes.

Parameters:
DATA_WIDTH, 32, word width in bits (power of two, at least 8).
DATA_ADDR_WIDTH, 32, byte address width.
NUM_SETS, 16, number of lines (power of two, at least 2).
WORDS_PER_LINE, 8, words per line and refill burst length (power of two, at least 2).

Ports:
cpu_clk  in  1  clock.
cpu_rst  in  1  reset, asynchronous, active-high.
cpu_data_mem_read  in  1  CPU read request.
cpu_data_mem_raddr  in  DATA_ADDR_WIDTH  CPU read byte address; word-aligned.
data_mem_rdata  out  DATA_WIDTH  read data; valid when read is requested and hazard=0.
data_mem_hazard  out  1  stall; CPU holds all request inputs while it is 1.
cpu_data_mem_write  in  1  CPU write request.
cpu_data_mem_waddr  in  DATA_ADDR_WIDTH  CPU write byte address.
cpu_data_mem_wdata  in  DATA_WIDTH  CPU write data.
mem_rd_req  out  1  line refill request.
mem_rd_addr  out  DATA_ADDR_WIDTH  line-aligned refill address.
mem_rd_ack  in  1  refill request accepted.
mem_rd_valid  in  1  refill beat valid.
mem_rd_data  in  DATA_WIDTH  refill beat data, ascending word order.
mem_wr_req  out  1  write-through request.
mem_wr_addr  out  DATA_ADDR_WIDTH  write-through address.
mem_wr_data  out  DATA_WIDTH  write-through data.
mem_wr_ack  in  1  write-through accepted.

Behaviour:
- Address fields: OFF = log2(DATA_WIDTH/8) bits; WOFF = log2(WORDS_PER_LINE) bits; IDX = log2(NUM_SETS) bits; TAG is the remainder. Defaults give 2/3/4/23 bits.
- Storage: valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS][WORDS_PER_LINE] in flops. Lookup is combinational: hit = valid[idx] && tag[idx]==addr_tag.
- Acceptance rule: a CPU request takes effect only in a cycle with data_mem_hazard=0.
- States: IDLE, RD_REQ, RD_FILL, WR_THRU.
- IDLE:
  - Read hit: rdata = data[idx][woff] in the same cycle (0 latency), hazard=0.
  - Read miss: hazard=1 combinationally; latch line address; go to RD_REQ.
  - Write with hazard=0: if hit, update data[idx][woff] at the edge. Latch addr/data; go to WR_THRU. A write miss leaves the array unchanged.
  - Read and write in the same cycle: read miss wins; the write waits, because hazard=1 blocks it. Read hit plus write: read returns the pre-write word, including when addresses are equal.
- RD_REQ: mem_rd_req=1, mem_rd_addr = {tag,idx,0...0}, held stable until the mem_rd_ack cycle. Then go to RD_FILL with beat counter=0.
- RD_FILL: each mem_rd_valid beat writes data[idx][cnt] and increments cnt. On beat WORDS_PER_LINE-1, set valid[idx] and tag[idx], go to IDLE. The next cycle is a hit, so hazard drops.
- WR_THRU: mem_wr_req=1 with latched addr/data until mem_wr_ack, then go to IDLE. Any CPU request in this state gets hazard=1.
- Hazard outside IDLE: 1 whenever read or write is requested; 0 with no request.
- Reset (any state, including mid-burst): state=IDLE; all valid=0; cnt=0; mem_rd_req, mem_wr_req, hazard, rdata = 0. A partially filled line stays invalid. The backing memory must tolerate an abandoned burst.
- Tag/data arrays are not reset.

Decomposition:
- Package l1_cache_pkg: state enum, field-width localparams (OFF, WOFF, IDX, TAG), address-slicing functions.
- Sub-module l1_tag_array: valid+tag storage, combinational hit compare, set-valid port, reset-clear of valid bits.

Test Plan:
- Cold read 0x40 (idx2, tag0) -> hazard=1; one mem_rd_req at 0x40; 8 beats 0xA0..0xA7; then read 0x44 returns 0xA1 with hazard=0, no new request.
- Conflict read 0x240 (idx2, tag1) after the line above -> refill at 0x240; then read 0x40 misses again.
- Write 0x48 = 0xDEAD on hit -> mem_wr_req addr 0x48 data 0xDEAD held across 3 stall cycles until ack; read 0x48 returns 0xDEAD. Write to a miss address 0x800 -> no refill, line stays invalid.
- Same-cycle read 0x48 hit + write 0x48 = 0x1 -> rdata is old 0xDEAD; next read returns 0x1.
- Read miss + write together -> refill completes first, then exactly one write-through (no duplicate).
- Assert cpu_rst after 4 refill beats -> req outputs 0 immediately; re-read of the same address misses and refetches all 8 beats.
